aes_key_expand: RTL and testbench
=================================

// Module: aes_key_expand
// PURPOSE
//  Key-schedule producer feeding aes_build. Takes the user key (128/192/256 bit), runs the
//  FIPS-197 KeyExpansion one 32-bit word per cycle, and presents the round keys on
//  key_words[15:1] with a level ready flag. aes_build treats a rising edge of ready as
//  "plain_text + key_words valid". Sits between the key input register and aes_build.
// PARAMETERS
//  NONE - widths fixed by FIPS-197; key_size selects Nk at run time.
// PORTS
//  eph1        in   1         clock, all state updates on posedge
//  reset       in   1         asynchronous, active-low; 0 clears all state immediately
//  start       in   1         one-cycle pulse; samples key_size/true_key, begins expansion
//  key_size    in   2         00=128b (Nk=4), 01=192b (Nk=6), 10|11=256b (Nk=8)
//  true_key    in   256       cipher key, MSB-aligned: 128b key in [255:128], 192b in [255:64]
//  key_words   out  15x128    [15:1][127:0]; [15]=round key 0, [15-r]=round key r; unused = 0
//  num_rounds  out  4         10/12/14 for captured key_size; 0 in IDLE after reset
//  busy        out  1         1 while expanding
//  ready       out  1         level; 1 from completion until next start or reset
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, key_words=0, num_rounds=0, busy=0, ready=0, rcon=8'h01.
//  - FSM: IDLE -start-> EXPAND -last word-> DONE -start-> EXPAND. No other transitions.
//  - Start edge (E0): capture key_size, true_key; write words w[0..Nk-1] into key_words store;
//    load 8x32 sliding window with last Nk words; i=Nk; rcon=8'h01; busy=1; ready=0.
//  - EXPAND, one word per edge: temp=w[i-1];
//      i%Nk==0         -> temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; rcon=xtime(rcon)
//      Nk==8 && i%Nk==4 -> temp = SubWord(temp)
//      w[i] = w[i-Nk] ^ temp; write into key_words word slot i; shift window; i++.
//  - xtime: {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00). Sequence 01,02,04,...,80,1B,36.
//  - SubWord uses the aeslib S-box, four instances, combinational within the cycle.
//  - Word slot i maps to key_words[15 - i/4], bits [127-32*(i%4) -: 32].
//  - Total words Nw = 44/52/60. Last word i=Nw-1 written on edge E(Nw-Nk) = E40/E46/E52;
//    on that same edge state=DONE, busy=0, ready=1. Latency start->ready: 40/46/52 edges.
//  - key_words rows beyond last round key (rows [4:1] for 128b, [2:1] for 192b) are 0.
//  - key_words and num_rounds hold stable in DONE. num_rounds updates on start edge.
//  - start while EXPAND: ignored (no restart, inputs not resampled).
//  - start while DONE: ready falls on that edge, key_words cleared then rewritten as above.
//  - start and reset together: reset wins.
//  - key_size/true_key changes outside the start edge have no effect.
//  - reset low mid-EXPAND: immediate return to reset values; no partial ready.
// TESTING
//  T1 128b: key 2b7e151628aed2a6abf7158809cf4f3c, start -> ready after 40 edges;
//     key_words[14]=a0fafe1788542cb123a339392a6c7605,
//     key_words[5]=d014f9a8c9ee2589e13f0cc8b6630ca6, rows[4:1]=0, num_rounds=10.
//  T2 192b: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> ready after 46 edges;
//     key_words[3]=e98ba06f448c773c8ecc720401002202, num_rounds=12.
//  T3 256b (key_size=11): key 603deb1015ca71be2b73aef0857d7781
//     1f352c073b6108d72d9810a30914dff4 -> ready after 52 edges;
//     key_words[1]=fe4890d1e6188d0b046df344706c631e.
//  T4 start pulsed again at edge E10 of a 128b run -> ignored; ready still at E40; T1 values.
//  T5 reset driven low at E20 asynchronously -> outputs 0 before next posedge; new start
//     re-runs T1 cleanly.
//  T6 end-to-end: T1 key into aes_build with plain_text 3243f6a8885a308d313198a2e0370734
//     -> ciphertext 3925841d02dc09fbdc118597196a0b32; decrypt output equals plain_text.

Source files
------------

// File: rtl/aes_key_expand.sv
// AES key schedule: expands a 128/192/256-bit key one 32-bit word per clock
// into the 15-row round-key store consumed by aes_build.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] pw;
    logic [7:0] inv;

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
    always_comb begin
        pw  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            pw  = gmul(pw, pw);
            inv = gmul(inv, pw);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand (
    input  logic               eph1,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         key_size,
    input  logic [255:0]       true_key,
    output logic [15:1][127:0] key_words,
    output logic [3:0]         num_rounds,
    output logic               busy,
    output logic               ready
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t            state, state_nxt;
    logic [7:0][31:0]  win;        // win[0] = w[i-1], win[k] = w[i-1-k]
    logic [5:0]        idx;
    logic [2:0]        cnt;        // idx mod Nk
    logic [2:0]        nkm1;       // Nk-1
    logic [7:0]        rcon;
    logic [5:0]        last_idx;
    logic              start_ok;
    logic              last;
    logic [31:0]       prev, sub_in, sub_out, temp, w_new;
    logic [3:0]        row;
    logic [2:0]        nkm1_in;
    logic [3:0]        rounds_in;
    logic [15:1][127:0] kw_init;
    logic [7:0][31:0]  win_init;

    assign busy     = (state == EXPAND);
    assign ready    = (state == DONE);
    assign start_ok = start && (state != EXPAND);
    assign last_idx = (nkm1 == 3'd3) ? 6'd43 : (nkm1 == 3'd5) ? 6'd51 : 6'd59;
    assign last     = (idx == last_idx);
    assign row      = 4'd15 - {2'b00, idx[5:2]};

    always_comb begin
        nkm1_in   = 3'd7;
        rounds_in = 4'd14;
        kw_init   = '0;
        win_init  = true_key;
        kw_init[15] = true_key[255:128];
        case (key_size)
            2'b00: begin
                nkm1_in   = 3'd3;
                rounds_in = 4'd10;
                win_init  = {128'h0, true_key[255:128]};
            end
            2'b01: begin
                nkm1_in     = 3'd5;
                rounds_in   = 4'd12;
                win_init    = {64'h0, true_key[255:64]};
                kw_init[14] = {true_key[127:64], 64'h0};
            end
            default: kw_init[14] = true_key[127:0];
        endcase
    end

    assign prev   = win[0];
    assign sub_in = (cnt == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .s(sub_out[8*b +: 8]));
    end

    always_comb begin
        temp = prev;
        if (cnt == 3'd0)
            temp = sub_out ^ {rcon, 24'h0};
        else if (nkm1 == 3'd7 && cnt == 3'd4)
            temp = sub_out;
        w_new = win[nkm1] ^ temp;
    end

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EXPAND;
            EXPAND:  if (last)  state_nxt = DONE;
            DONE:    if (start) state_nxt = EXPAND;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            key_words  <= '0;
            num_rounds <= '0;
            win        <= '0;
            idx        <= '0;
            cnt        <= '0;
            nkm1       <= '0;
            rcon       <= 8'h01;
        end else if (start_ok) begin
            key_words  <= kw_init;
            num_rounds <= rounds_in;
            win        <= win_init;
            idx        <= {3'b000, nkm1_in} + 6'd1;
            cnt        <= '0;
            nkm1       <= nkm1_in;
            rcon       <= 8'h01;
        end else if (state == EXPAND) begin
            key_words[row][{~idx[1:0], 5'b0} +: 32] <= w_new;
            win  <= {win[6:0], w_new};
            idx  <= idx + 6'd1;
            cnt  <= (cnt == nkm1) ? 3'd0 : cnt + 3'd1;
            if (cnt == 3'd0)
                rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand using the FIPS-197 appendix A key vectors.

module tb_aes_key_expand;
    logic               eph1 = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [1:0]         key_size = '0;
    logic [255:0]       true_key = '0;
    logic [15:1][127:0] key_words;
    logic [3:0]         num_rounds;
    logic               busy;
    logic               ready;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string        tag;
        int           lat;
        logic [3:0]   rounds;
        logic [127:0] r15, r14, r13;
        int           rl_idx;
        logic [127:0] rl;
        int           zero_hi;
    } exp_t;

    exp_t sb[$];

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_expand dut (
        .eph1(eph1), .reset(reset), .start(start), .key_size(key_size),
        .true_key(true_key), .key_words(key_words), .num_rounds(num_rounds),
        .busy(busy), .ready(ready)
    );

    always #5 eph1 = ~eph1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else             n_pass++;
    endtask

    function automatic exp_t exp128(input string tag);
        exp_t e;
        e.tag = tag; e.lat = 40; e.rounds = 4'd10;
        e.r15 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        e.r14 = 128'ha0fafe1788542cb123a339392a6c7605;
        e.r13 = 128'hf2c295f27a96b9435935807a7359f67f;
        e.rl_idx = 5; e.rl = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6; e.zero_hi = 4;
        return e;
    endfunction

    // Drives one start pulse, pushes the expectation, waits for ready and scores it.
    // pulse_at > 0 re-pulses start (with different inputs) at that edge of the run.
    task automatic run(input logic [1:0] ks, input logic [255:0] k, input exp_t e, input int pulse_at);
        exp_t g;
        int   n;
        key_size = ks;
        true_key = k;
        start    = 1'b1;
        sb.push_back(e);
        @(posedge eph1); #1;
        start = 1'b0;
        check({e.tag, "_busy_e0"}, 128'(busy), 128'd1);
        check({e.tag, "_rdy_e0"}, 128'(ready), 128'd0);
        check({e.tag, "_row13_e0"}, key_words[13], 128'd0);
        n = 0;
        while (!ready && n < 200) begin
            if (n == pulse_at - 1) begin
                start = 1'b1; key_size = 2'b01; true_key = ~k;
            end else begin
                start = 1'b0;
            end
            @(posedge eph1); #1;
            n++;
        end
        start = 1'b0;
        g = sb.pop_front();
        check({g.tag, "_lat"}, 128'(n), 128'(g.lat));
        check({g.tag, "_busy"}, 128'(busy), 128'd0);
        check({g.tag, "_rounds"}, 128'(num_rounds), 128'(g.rounds));
        check({g.tag, "_r15"}, key_words[15], g.r15);
        check({g.tag, "_r14"}, key_words[14], g.r14);
        check({g.tag, "_r13"}, key_words[13], g.r13);
        check({g.tag, "_rlast"}, key_words[g.rl_idx], g.rl);
        for (int r = 1; r <= g.zero_hi; r++)
            check($sformatf("%s_zero%0d", g.tag, r), key_words[r], 128'd0);
    endtask

    initial begin
        exp_t e;
        #3;
        for (int r = 1; r <= 15; r++)
            check($sformatf("rst_kw%0d", r), key_words[r], 128'd0);
        check("rst_rounds", 128'(num_rounds), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ready", 128'(ready), 128'd0);
        @(posedge eph1); #1;
        reset = 1'b1;
        @(posedge eph1); #1;

        run(2'b00, K128, exp128("t1"), -1);

        e.tag = "t2"; e.lat = 46; e.rounds = 4'd12;
        e.r15 = 128'h8e73b0f7da0e6452c810f32b809079e5;
        e.r14 = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
        e.r13 = 128'hec12068e6c827f6b0e7a95b95c56fec2;
        e.rl_idx = 3; e.rl = 128'he98ba06f448c773c8ecc720401002202; e.zero_hi = 2;
        run(2'b01, K192, e, -1);

        e.tag = "t3"; e.lat = 52; e.rounds = 4'd14;
        e.r15 = 128'h603deb1015ca71be2b73aef0857d7781;
        e.r14 = 128'h1f352c073b6108d72d9810a30914dff4;
        e.r13 = 128'h9ba354118e6925afa51a8b5f2067fcde;
        e.rl_idx = 1; e.rl = 128'hfe4890d1e6188d0b046df344706c631e; e.zero_hi = 0;
        run(2'b11, K256, e, -1);

        // Inputs moving while DONE must not disturb the held key schedule.
        true_key = ~K256; key_size = 2'b00;
        repeat (5) @(posedge eph1);
        #1;
        check("hold_r1", key_words[1], 128'hfe4890d1e6188d0b046df344706c631e);
        check("hold_ready", 128'(ready), 128'd1);
        check("hold_rounds", 128'(num_rounds), 128'd14);

        run(2'b00, K128, exp128("t4"), 10);

        key_size = 2'b00; true_key = K128; start = 1'b1;
        @(posedge eph1); #1;
        start = 1'b0;
        repeat (20) @(posedge eph1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_busy", 128'(busy), 128'd0);
        check("t5_ready", 128'(ready), 128'd0);
        check("t5_rounds", 128'(num_rounds), 128'd0);
        check("t5_r15", key_words[15], 128'd0);
        check("t5_r14", key_words[14], 128'd0);
        @(posedge eph1); #1;
        reset = 1'b1;
        @(posedge eph1); #1;
        check("t5_idle", 128'(busy), 128'd0);

        run(2'b00, K128, exp128("t5r"), -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
